// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 memory arbiter.
package axi_arb_pkg;

    localparam int ID_W_DEF   = 5;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;

    // Source tag prepended to every downstream ID
    localparam logic SRC_M0 = 1'b0;
    localparam logic SRC_M1 = 1'b1;

    typedef enum logic {
        AR_IDLE,
        AR_GRANT
    } ar_state_t;

    typedef enum logic [1:0] {
        AW_IDLE,
        AW_ADDR,
        W_DATA
    } aw_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The pointer remembers the last master that
// completed an address handshake; on a tie the other master wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic last;

    assign grant = (req == 2'b11) ? ~last : req[1];

    // Pointer starts at master 1 so master 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// Shares one downstream AXI4 memory port between two upstream masters.
// AR and AW/W are arbitrated independently; R and B are routed back by
// the source bit prepended to the downstream ID.
//
// state     | meaning
// ----------|--------------------------------------------------------
// AR_IDLE   | no read grant; pick a requester, register it
// AR_GRANT  | granted AR passes through until the m_ar handshake
// AW_IDLE   | no write grant; pick a requester, register it
// AW_ADDR   | granted AW passes through until the m_aw handshake
// W_DATA    | granted W passes through until the wlast handshake
module axi4_mem_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    // master 0 read address
    input  logic [ID_W-1:0]     s0_arid,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic [7:0]          s0_arlen,
    input  logic [2:0]          s0_arsize,
    input  logic [1:0]          s0_arburst,
    input  logic                s0_arlock,
    input  logic [3:0]          s0_arcache,
    input  logic [2:0]          s0_arprot,
    input  logic [3:0]          s0_arqos,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    // master 0 write address
    input  logic [ID_W-1:0]     s0_awid,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic [7:0]          s0_awlen,
    input  logic [2:0]          s0_awsize,
    input  logic [1:0]          s0_awburst,
    input  logic                s0_awlock,
    input  logic [3:0]          s0_awcache,
    input  logic [2:0]          s0_awprot,
    input  logic [3:0]          s0_awqos,
    input  logic                s0_awvalid,
    output logic                s0_awready,
    // master 0 write data
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wlast,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    // master 0 write response
    output logic [ID_W-1:0]     s0_bid,
    output logic [1:0]          s0_bresp,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    // master 0 read data
    output logic [ID_W-1:0]     s0_rid,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    output logic                s0_rlast,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    // master 1 read address
    input  logic [ID_W-1:0]     s1_arid,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic [7:0]          s1_arlen,
    input  logic [2:0]          s1_arsize,
    input  logic [1:0]          s1_arburst,
    input  logic                s1_arlock,
    input  logic [3:0]          s1_arcache,
    input  logic [2:0]          s1_arprot,
    input  logic [3:0]          s1_arqos,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    // master 1 write address
    input  logic [ID_W-1:0]     s1_awid,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [7:0]          s1_awlen,
    input  logic [2:0]          s1_awsize,
    input  logic [1:0]          s1_awburst,
    input  logic                s1_awlock,
    input  logic [3:0]          s1_awcache,
    input  logic [2:0]          s1_awprot,
    input  logic [3:0]          s1_awqos,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    // master 1 write data
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wlast,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    // master 1 write response
    output logic [ID_W-1:0]     s1_bid,
    output logic [1:0]          s1_bresp,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    // master 1 read data
    output logic [ID_W-1:0]     s1_rid,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic                s1_rlast,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    // downstream read address
    output logic [ID_W:0]       m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic [3:0]          m_arqos,
    output logic                m_arvalid,
    input  logic                m_arready,
    // downstream write address
    output logic [ID_W:0]       m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic [3:0]          m_awqos,
    output logic                m_awvalid,
    input  logic                m_awready,
    // downstream write data
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    // downstream write response
    input  logic [ID_W:0]       m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    // downstream read data
    input  logic [ID_W:0]       m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready
);

    ar_state_t  ar_state;
    aw_state_t  aw_state;
    logic       ar_sel;
    logic       aw_sel;
    logic [1:0] ar_req;
    logic [1:0] aw_req;
    logic       ar_pick;
    logic       aw_pick;
    logic       ar_hs;
    logic       aw_hs;
    logic       w_last_hs;
    logic       ar_on;
    logic       aw_on;
    logic       w_on;
    logic       r_dst;
    logic       b_dst;

    assign ar_on = (ar_state == AR_GRANT);
    assign aw_on = (aw_state == AW_ADDR);
    assign w_on  = (aw_state == W_DATA);

    // While granted, the picker only sees the held grant, so the pointer
    // update on the handshake records the master that actually completed.
    assign ar_req = (ar_state == AR_IDLE) ? {s1_arvalid, s0_arvalid} : {ar_sel, ~ar_sel};
    assign aw_req = (aw_state == AW_IDLE) ? {s1_awvalid, s0_awvalid} : {aw_sel, ~aw_sel};

    assign ar_hs     = m_arvalid & m_arready;
    assign aw_hs     = m_awvalid & m_awready;
    assign w_last_hs = m_wvalid & m_wready & m_wlast;

    rr_arb2 u_ar_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (ar_req),
        .update (ar_hs),
        .grant  (ar_pick)
    );

    rr_arb2 u_aw_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (aw_req),
        .update (aw_hs),
        .grant  (aw_pick)
    );

    // Read address FSM: register the grant in IDLE, hold it until handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_state <= AR_IDLE;
            ar_sel   <= SRC_M0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (|ar_req) begin
                        ar_sel   <= ar_pick;
                        ar_state <= AR_GRANT;
                    end
                end
                AR_GRANT: begin
                    if (ar_hs) begin
                        ar_state <= AR_IDLE;
                    end
                end
                default: ar_state <= AR_IDLE;
            endcase
        end
    end

    // Write FSM: address phase then data phase, locked to one master until wlast
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_state <= AW_IDLE;
            aw_sel   <= SRC_M0;
        end else begin
            case (aw_state)
                AW_IDLE: begin
                    if (|aw_req) begin
                        aw_sel   <= aw_pick;
                        aw_state <= AW_ADDR;
                    end
                end
                AW_ADDR: begin
                    if (aw_hs) begin
                        aw_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_last_hs) begin
                        aw_state <= AW_IDLE;
                    end
                end
                default: aw_state <= AW_IDLE;
            endcase
        end
    end

    assign m_arid     = {ar_sel, (ar_sel ? s1_arid : s0_arid)};
    assign m_araddr   = ar_sel ? s1_araddr  : s0_araddr;
    assign m_arlen    = ar_sel ? s1_arlen   : s0_arlen;
    assign m_arsize   = ar_sel ? s1_arsize  : s0_arsize;
    assign m_arburst  = ar_sel ? s1_arburst : s0_arburst;
    assign m_arlock   = ar_sel ? s1_arlock  : s0_arlock;
    assign m_arcache  = ar_sel ? s1_arcache : s0_arcache;
    assign m_arprot   = ar_sel ? s1_arprot  : s0_arprot;
    assign m_arqos    = ar_sel ? s1_arqos   : s0_arqos;
    assign m_arvalid  = ar_on & (ar_sel ? s1_arvalid : s0_arvalid);
    assign s0_arready = ar_on & (ar_sel == SRC_M0) & m_arready;
    assign s1_arready = ar_on & (ar_sel == SRC_M1) & m_arready;

    assign m_awid     = {aw_sel, (aw_sel ? s1_awid : s0_awid)};
    assign m_awaddr   = aw_sel ? s1_awaddr  : s0_awaddr;
    assign m_awlen    = aw_sel ? s1_awlen   : s0_awlen;
    assign m_awsize   = aw_sel ? s1_awsize  : s0_awsize;
    assign m_awburst  = aw_sel ? s1_awburst : s0_awburst;
    assign m_awlock   = aw_sel ? s1_awlock  : s0_awlock;
    assign m_awcache  = aw_sel ? s1_awcache : s0_awcache;
    assign m_awprot   = aw_sel ? s1_awprot  : s0_awprot;
    assign m_awqos    = aw_sel ? s1_awqos   : s0_awqos;
    assign m_awvalid  = aw_on & (aw_sel ? s1_awvalid : s0_awvalid);
    assign s0_awready = aw_on & (aw_sel == SRC_M0) & m_awready;
    assign s1_awready = aw_on & (aw_sel == SRC_M1) & m_awready;

    // Early W beats stall here until the matching AW has been accepted
    assign m_wdata   = aw_sel ? s1_wdata : s0_wdata;
    assign m_wstrb   = aw_sel ? s1_wstrb : s0_wstrb;
    assign m_wlast   = aw_sel ? s1_wlast : s0_wlast;
    assign m_wvalid  = w_on & (aw_sel ? s1_wvalid : s0_wvalid);
    assign s0_wready = w_on & (aw_sel == SRC_M0) & m_wready;
    assign s1_wready = w_on & (aw_sel == SRC_M1) & m_wready;

    // Responses: route by the tag bit; ready is qualified by valid so the
    // downstream ready is low whenever no response is offered (incl. reset).
    assign r_dst     = m_rid[ID_W];
    assign s0_rid    = m_rid[ID_W-1:0];
    assign s1_rid    = m_rid[ID_W-1:0];
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;
    assign s0_rvalid = m_rvalid & (r_dst == SRC_M0);
    assign s1_rvalid = m_rvalid & (r_dst == SRC_M1);
    assign m_rready  = m_rvalid & (r_dst ? s1_rready : s0_rready);

    assign b_dst     = m_bid[ID_W];
    assign s0_bid    = m_bid[ID_W-1:0];
    assign s1_bid    = m_bid[ID_W-1:0];
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;
    assign s0_bvalid = m_bvalid & (b_dst == SRC_M0);
    assign s1_bvalid = m_bvalid & (b_dst == SRC_M1);
    assign m_bready  = m_bvalid & (b_dst ? s1_bready : s0_bready);

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter: grant order, pass-through, W locking,
// response routing, backpressure and asynchronous reset.
module tb_axi4_mem_arbiter;

    localparam int ID_W   = 5;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic reset;

    logic [ID_W-1:0] s0_arid, s1_arid, s0_awid, s1_awid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr;
    logic [7:0] s0_arlen, s1_arlen, s0_awlen, s1_awlen;
    logic [2:0] s0_arsize, s1_arsize, s0_awsize, s1_awsize;
    logic [1:0] s0_arburst, s1_arburst, s0_awburst, s1_awburst;
    logic s0_arlock, s1_arlock, s0_awlock, s1_awlock;
    logic [3:0] s0_arcache, s1_arcache, s0_awcache, s1_awcache;
    logic [2:0] s0_arprot, s1_arprot, s0_awprot, s1_awprot;
    logic [3:0] s0_arqos, s1_arqos, s0_awqos, s1_awqos;
    logic s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid;
    logic s0_arready, s1_arready, s0_awready, s1_awready;
    logic [DATA_W-1:0] s0_wdata, s1_wdata;
    logic [DATA_W/8-1:0] s0_wstrb, s1_wstrb;
    logic s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
    logic [ID_W-1:0] s0_bid, s1_bid, s0_rid, s1_rid;
    logic [1:0] s0_bresp, s1_bresp, s0_rresp, s1_rresp;
    logic s0_bvalid, s1_bvalid, s0_bready, s1_bready;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;

    logic [ID_W:0] m_arid, m_awid, m_bid, m_rid;
    logic [ADDR_W-1:0] m_araddr, m_awaddr;
    logic [7:0] m_arlen, m_awlen;
    logic [2:0] m_arsize, m_awsize, m_arprot, m_awprot;
    logic [1:0] m_arburst, m_awburst, m_bresp, m_rresp;
    logic m_arlock, m_awlock;
    logic [3:0] m_arcache, m_awcache, m_arqos, m_awqos;
    logic m_arvalid, m_arready, m_awvalid, m_awready;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic m_wlast, m_wvalid, m_wready;
    logic m_bvalid, m_bready;
    logic m_rlast, m_rvalid, m_rready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4_mem_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache),
        .s0_arprot(s0_arprot), .s0_arqos(s0_arqos), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
        .s0_awburst(s0_awburst), .s0_awlock(s0_awlock), .s0_awcache(s0_awcache),
        .s0_awprot(s0_awprot), .s0_awqos(s0_awqos), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
        .s0_wready(s0_wready),
        .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache),
        .s1_arprot(s1_arprot), .s1_arqos(s1_arqos), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
        .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache),
        .s1_awprot(s1_awprot), .s1_awqos(s1_awqos), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
        .s1_wready(s1_wready),
        .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wd(int b);
        return 64'hD000_0000_0000_0000 + 64'(b);
    endfunction

    task automatic init_inputs();
        reset = 1'b1;
        {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot, s0_arqos, s0_arvalid} = '0;
        {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot, s1_arqos, s1_arvalid} = '0;
        {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot, s0_awqos, s0_awvalid} = '0;
        {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot, s1_awqos, s1_awvalid} = '0;
        {s0_wdata, s0_wstrb, s0_wlast, s0_wvalid, s1_wdata, s1_wstrb, s1_wlast, s1_wvalid} = '0;
        {s0_bready, s1_bready, s0_rready, s1_rready} = '0;
        {m_arready, m_awready, m_wready} = '0;
        {m_bid, m_bresp, m_bvalid, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid} = '0;
    endtask

    task automatic test_reset();
        s0_arvalid = 1'b1;
        s0_rready  = 1'b1;
        s1_bready  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s0_arready, s1_arready,
             s0_awready, s1_awready, s0_wready, s1_wready, s0_rvalid, s1_rvalid,
             s0_bvalid, s1_bvalid} !== 15'b0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want all zero", {m_arvalid, m_awvalid, m_wvalid,
                     m_rready, m_bready, s0_arready, s1_arready, s0_awready, s1_awready,
                     s0_wready, s1_wready, s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid});
        end
        tick();
        reset      = 1'b0;
        s0_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s1_bready  = 1'b0;
    endtask

    task automatic test_ar_tie();
        logic [5:0] exp_id [4];
        exp_id = '{6'h03, 6'h25, 6'h03, 6'h25};
        tick();
        s0_arvalid = 1'b1; s0_arid = 5'd3;
        s1_arvalid = 1'b1; s1_arid = 5'd5;
        m_arready  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            n_vec++;
            if (m_arvalid !== 1'b0) begin
                n_err++;
                $display("FAIL ar_tie_idle[%0d] got m_arvalid=%b want 0", g, m_arvalid);
            end
            @(negedge clk);
            n_vec++;
            if ({m_arvalid, m_arid, s1_arready, s0_arready} !==
                {1'b1, exp_id[g], exp_id[g][5], ~exp_id[g][5]}) begin
                n_err++;
                $display("FAIL ar_tie_grant[%0d] got valid=%b id=%h rdy1=%b rdy0=%b want id=%h",
                         g, m_arvalid, m_arid, s1_arready, s0_arready, exp_id[g]);
            end
        end
        tick();
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        m_arready  = 1'b0;
    endtask

    task automatic test_read_basic();
        s0_arvalid = 1'b1; s0_arid = 5'd3; s0_araddr = 32'h8000_0000; s0_arlen = 8'd7;
        m_arready  = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_latency got m_arvalid=%b want 0 in arbitration cycle", m_arvalid);
        end
        @(negedge clk);
        n_vec++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen, s0_arready} !==
            {1'b1, 6'h03, 32'h8000_0000, 8'd7, 1'b0}) begin
            n_err++;
            $display("FAIL rd_ar_fwd got valid=%b id=%h addr=%h len=%0d rdy=%b want 1 03 80000000 7 0",
                     m_arvalid, m_arid, m_araddr, m_arlen, s0_arready);
        end
        tick();
        m_arready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s0_arready !== 1'b1) begin
            n_err++;
            $display("FAIL rd_arready_follow got %b want 1", s0_arready);
        end
        tick();
        s0_arvalid = 1'b0;
        m_arready  = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_back_idle got m_arvalid=%b want 0", m_arvalid);
        end
        s0_rready = 1'b1;
        s1_rready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            tick();
            m_rvalid = 1'b1; m_rid = 6'h03;
            m_rdata  = 64'hA5A5_0000_0000_0000 + 64'(b);
            m_rlast  = (b == 7);
            @(negedge clk);
            n_vec++;
            if ({s0_rvalid, s1_rvalid, s0_rid, s0_rdata, s0_rlast, m_rready} !==
                {1'b1, 1'b0, 5'd3, 64'hA5A5_0000_0000_0000 + 64'(b), (b == 7), 1'b1}) begin
                n_err++;
                $display("FAIL rd_r_route[%0d] got v0=%b v1=%b id=%h data=%h last=%b mrdy=%b",
                         b, s0_rvalid, s1_rvalid, s0_rid, s0_rdata, s0_rlast, m_rready);
            end
        end
        tick();
        m_rid = 6'h25; m_rlast = 1'b1; s1_rready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({s0_rvalid, s1_rvalid, s1_rid, m_rready} !== {1'b0, 1'b1, 5'd5, 1'b0}) begin
            n_err++;
            $display("FAIL rd_r_route_m1 got v0=%b v1=%b id=%h mrdy=%b want 0 1 05 0",
                     s0_rvalid, s1_rvalid, s1_rid, m_rready);
        end
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k    = 0;
        int mcnt = 0;
        int cyc  = 0;
        while (k < 4 && cyc < 20) begin
            tick();
            s0_rready = cyc[0];
            m_rvalid  = 1'b1; m_rid = 6'h02;
            m_rdata   = 64'h1000 + 64'(k);
            m_rlast   = (k == 3);
            @(negedge clk);
            n_vec++;
            if (m_rready !== s0_rready) begin
                n_err++;
                $display("FAIL bp_rready_track[%0d] got %b want %b", cyc, m_rready, s0_rready);
            end
            if (s0_rvalid && s0_rready) begin
                n_vec++;
                if (s0_rdata !== 64'h1000 + 64'(mcnt)) begin
                    n_err++;
                    $display("FAIL bp_order got %h want %h", s0_rdata, 64'h1000 + 64'(mcnt));
                end
                mcnt++;
            end
            if (m_rready) k++;
            cyc++;
        end
        n_vec++;
        if (mcnt !== 4 || cyc !== 8) begin
            n_err++;
            $display("FAIL bp_beat_count got beats=%0d cycles=%0d want 4 8", mcnt, cyc);
        end
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0;

        s1_arvalid = 1'b1; s1_arid = 5'd7; m_arready = 1'b0;
        @(negedge clk);
        tick();
        s0_arvalid = 1'b1; s0_arid = 5'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({m_arvalid, m_arid, s1_arready, s0_arready} !== {1'b1, 6'h27, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL ar_stall[%0d] got valid=%b id=%h rdy1=%b rdy0=%b want 1 27 0 0",
                         i, m_arvalid, m_arid, s1_arready, s0_arready);
            end
        end
        tick();
        m_arready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({s1_arready, s0_arready, m_arid} !== {1'b1, 1'b0, 6'h27}) begin
            n_err++;
            $display("FAIL ar_stall_release got rdy1=%b rdy0=%b id=%h", s1_arready, s0_arready, m_arid);
        end
        tick();
        s1_arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({m_arvalid, m_arid, s0_arready} !== {1'b1, 6'h01, 1'b1}) begin
            n_err++;
            $display("FAIL ar_pending_m0 got valid=%b id=%h rdy0=%b want 1 01 1", m_arvalid, m_arid, s0_arready);
        end
        tick();
        s0_arvalid = 1'b0;
        m_arready  = 1'b0;
    endtask

    task automatic test_aw_burst();
        m_wready = 1'b1; m_awready = 1'b0;
        s1_awvalid = 1'b1; s1_awid = 5'd1; s1_awlen = 8'd3;
        s1_wvalid = 1'b1; s1_wdata = wd(0); s1_wlast = 1'b0; s1_wstrb = '1;
        @(negedge clk);
        n_vec++;
        if ({m_awvalid, m_wvalid, s1_wready, s1_awready} !== 4'b0) begin
            n_err++;
            $display("FAIL w_early_idle got awv=%b wv=%b wrdy=%b awrdy=%b want 0",
                     m_awvalid, m_wvalid, s1_wready, s1_awready);
        end
        tick();
        s0_awvalid = 1'b1; s0_awid = 5'd2; s0_awlen = 8'd0;
        @(negedge clk);
        n_vec++;
        if ({m_awvalid, m_awid, m_awlen, m_wvalid, s1_wready, s0_awready} !==
            {1'b1, 6'h21, 8'd3, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL aw_m1_fwd got awv=%b id=%h len=%0d wv=%b wrdy=%b awrdy0=%b",
                     m_awvalid, m_awid, m_awlen, m_wvalid, s1_wready, s0_awready);
        end
        tick();
        m_awready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({s1_awready, s0_awready, m_wvalid, s1_wready} !== 4'b1000) begin
            n_err++;
            $display("FAIL aw_m1_hs got %b want 1000", {s1_awready, s0_awready, m_wvalid, s1_wready});
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            s1_awvalid = 1'b0;
            s1_wdata   = wd(b);
            s1_wlast   = (b == 3);
            @(negedge clk);
            n_vec++;
            if ({m_wvalid, s1_wready, s0_wready, s0_awready, m_awvalid, m_wlast, m_wdata} !==
                {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (b == 3), wd(b)}) begin
                n_err++;
                $display("FAIL w_beat[%0d] got wv=%b rdy1=%b rdy0=%b awrdy0=%b awv=%b last=%b data=%h",
                         b, m_wvalid, s1_wready, s0_wready, s0_awready, m_awvalid, m_wlast, m_wdata);
            end
        end
        tick();
        s1_wvalid = 1'b0; s1_wlast = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m_awvalid, s0_awready, m_wvalid} !== 3'b0) begin
            n_err++;
            $display("FAIL aw_idle_after_w got %b want 000", {m_awvalid, s0_awready, m_wvalid});
        end
        @(negedge clk);
        n_vec++;
        if ({m_awvalid, m_awid, s0_awready} !== {1'b1, 6'h02, 1'b1}) begin
            n_err++;
            $display("FAIL aw_m0_after got awv=%b id=%h rdy0=%b want 1 02 1", m_awvalid, m_awid, s0_awready);
        end
        tick();
        s0_awvalid = 1'b0;
        s0_wvalid = 1'b1; s0_wdata = 64'hBEEF; s0_wlast = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({m_wvalid, s0_wready, m_wlast, m_wdata} !== {1'b1, 1'b1, 1'b1, 64'hBEEF}) begin
            n_err++;
            $display("FAIL w_m0_single got wv=%b rdy=%b last=%b data=%h", m_wvalid, s0_wready, m_wlast, m_wdata);
        end
        tick();
        s0_wvalid = 1'b0; s0_wlast = 1'b0; m_awready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m_wvalid, s0_wready} !== 2'b00) begin
            n_err++;
            $display("FAIL w_m0_done got wv=%b rdy=%b want 0 0", m_wvalid, s0_wready);
        end
        tick();
        m_bvalid = 1'b1; m_bid = 6'h21; m_bresp = 2'b00; s1_bready = 1'b1; s0_bready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({s1_bvalid, s0_bvalid, s1_bid, m_bready} !== {1'b1, 1'b0, 5'd1, 1'b1}) begin
            n_err++;
            $display("FAIL b_route_m1 got v1=%b v0=%b id=%h rdy=%b want 1 0 01 1", s1_bvalid, s0_bvalid, s1_bid, m_bready);
        end
        tick();
        m_bid = 6'h02; m_bresp = 2'b10; s0_bready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({s0_bvalid, s1_bvalid, s0_bid, s0_bresp, m_bready} !== {1'b1, 1'b0, 5'd2, 2'b10, 1'b0}) begin
            n_err++;
            $display("FAIL b_route_m0 got v0=%b v1=%b id=%h resp=%b rdy=%b", s0_bvalid, s1_bvalid, s0_bid, s0_bresp, m_bready);
        end
        tick();
        m_bvalid = 1'b0; s0_bready = 1'b0; s1_bready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        s0_awvalid = 1'b1; s0_awid = 5'd4; s0_awlen = 8'd3;
        m_awready = 1'b1; m_wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick();
        s0_awvalid = 1'b0;
        s0_wvalid = 1'b1; s0_wdata = wd(0); s0_wlast = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m_wvalid, s0_wready} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_beat1 got wv=%b rdy=%b want 1 1", m_wvalid, s0_wready);
        end
        tick();
        s0_wdata = wd(1);
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s0_arready, s1_arready,
             s0_awready, s1_awready, s0_wready, s1_wready} !== 11'b0) begin
            n_err++;
            $display("FAIL rst_async got %b want all zero", {m_arvalid, m_awvalid, m_wvalid,
                     m_rready, m_bready, s0_arready, s1_arready, s0_awready, s1_awready,
                     s0_wready, s1_wready});
        end
        tick();
        tick();
        reset = 1'b0;
        s0_wvalid = 1'b0;
        s0_awvalid = 1'b1; s0_awid = 5'd6;
        s1_awvalid = 1'b1; s1_awid = 5'd9;
        @(negedge clk);
        n_vec++;
        if (m_awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_fresh_idle got m_awvalid=%b want 0", m_awvalid);
        end
        @(negedge clk);
        n_vec++;
        if ({m_awvalid, m_awid, s0_awready, s1_awready} !== {1'b1, 6'h06, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rst_fresh_aw got awv=%b id=%h rdy0=%b rdy1=%b want 1 06 1 0",
                     m_awvalid, m_awid, s0_awready, s1_awready);
        end
        tick();
        s0_awvalid = 1'b0; s1_awvalid = 1'b0; m_awready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_inputs();
        test_reset();
        test_ar_tie();
        test_read_basic();
        test_backpressure();
        test_aw_burst();
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
